sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
- Shares one downstream sram-like memory port between the instruction-fetch requester (port I) and the load/store requester (port D).
- Forwards one request per cycle and tracks accepted-but-unanswered requests in an in-order ID FIFO.
- Routes each downstream data_ok back to the requester that issued it.
- Sits between the IF/MEM stages and the SRAM/AXI bridge.

Parameters:
- OT_DEPTH, 4: maximum outstanding accepted requests (power of two, 2..16).
- CNT_W, $clog2(OT_DEPTH+1): width of the outstanding counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- inst_req / inst_wr  in  1 / 1  port I request, write flag.
- inst_size / inst_wstrb  in  2 / 4  port I size, byte strobes.
- inst_addr / inst_wdata  in  32 / 32  port I address, write data.
- inst_addr_ok / inst_data_ok  out  1 / 1  port I request accepted / response valid.
- inst_rdata  out  32  port I read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and meaning for port D.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  downstream request.
- mem_addr_ok  in  1  downstream accept.
- mem_data_ok  in  1  downstream response valid.
- mem_rdata  in  32  downstream read data.
- ot_cnt  out  CNT_W  current outstanding count.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (resetn=0, asynchronous): FIFO emptied, ot_cnt=0, lock cleared, proto_err=0.
  - While in reset, every out-handshake (mem_req, *_addr_ok, *_data_ok) is 0.
- Grant selection (combinational):
  - If lock is valid, grant = lock_id.
  - Otherwise grant = D if data_req, else I. Fixed priority D over I.
- full = (ot_cnt == OT_DEPTH).
  - No bypass: a pop in the same cycle does not unblock a push.
- Request forwarding (combinational):
  - mem_req = granted requester's req && !full.
  - mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata are muxed from the granted requester.
- Accept:
  - granted *_addr_ok = mem_req && mem_addr_ok.
  - Non-granted *_addr_ok = 0.
  - On accept, push the grant ID (0=I, 1=D) into the FIFO.
- Lock register:
  - Set with lock_id = grant when mem_req && !mem_addr_ok.
  - Cleared on accept.
  - Cleared when the locked requester deasserts req. Grant is then re-evaluated in that same cycle.
  - Purpose: a stalled request keeps the port; a later D request cannot pre-empt a pending I request.
- Response routing:
  - pop = mem_data_ok && ot_cnt != 0.
  - inst_data_ok = pop && head==I; data_data_ok = pop && head==D.
  - inst_rdata = data_rdata = mem_rdata, unconditionally.
  - Write requests also receive exactly one data_ok.
- Counter update:
  - push only: ot_cnt+1.
  - pop only: ot_cnt-1.
  - push and pop together: count unchanged, head advances, tail writes.
  - FIFO read/write pointers are log2(OT_DEPTH) bits and wrap naturally.
- Spurious response: mem_data_ok while ot_cnt==0 is dropped. No requester data_ok is raised, and proto_err is set to 1 until reset.
- Downstream contract: mem_data_ok for a request comes no earlier than the cycle after its mem_addr_ok. The arbiter never routes a response in the cycle its request was accepted.
- Latency: zero added cycles on either the request path or the response path.
- Reset mid-operation: outstanding entries are discarded. Late mem_data_ok after reset counts as spurious and sets proto_err.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0x1c000000, mem_addr_ok=1 in cycle 0; mem_data_ok=1 with mem_rdata=0x12345678 in cycle 2.
  -> mem_addr=0x1c000000 and inst_addr_ok=1 in cycle 0; ot_cnt=1 in cycles 1-2; inst_data_ok=1 with inst_rdata=0x12345678 in cycle 2; data_data_ok=0; ot_cnt=0 in cycle 3.
- Contention: inst_req and data_req both high, data_addr=0x00001000, inst_addr=0x1c000004, mem_addr_ok always 1.
  -> cycle 0 forwards 0x00001000 (data_addr_ok=1); cycle 1 forwards 0x1c000004; two responses route D first, then I.
- Lock: inst_req high at 0x1c000008, mem_addr_ok=0 for cycles 0-2, data_req rises in cycle 1, mem_addr_ok=1 in cycle 3.
  -> mem_addr=0x1c000008 through cycle 3; inst_addr_ok only in cycle 3; data request forwarded in cycle 4.
- Full, OT_DEPTH=4: four accepts with no mem_data_ok.
  -> ot_cnt=4; a fifth request gives mem_req=0 and *_addr_ok=0. One mem_data_ok gives ot_cnt=3 the next cycle, and the fifth request is forwarded that cycle.
- Simultaneous push/pop plus spurious response:
  - With ot_cnt=2, accept and mem_data_ok in the same cycle -> ot_cnt stays 2; the data_ok goes to the oldest ID.
  - Drain to 0, then pulse mem_data_ok -> no *_data_ok, proto_err=1 and it holds.
- Async reset: with ot_cnt=2 and lock set, drop resetn mid-cycle.
  -> ot_cnt=0, mem_req=0, proto_err=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/sram_req_arbiter_if.sv
// Request/response bundle for the I/D requesters and the shared downstream port.
// slave = arbiter side, master = requesters plus downstream memory.
interface sram_req_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_wstrb,
        input  inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb,
        input  data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb,
        output mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_wstrb,
        output inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb,
        output data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb,
        input  mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-requester (I/D) arbiter for one sram-like port, D priority with stall lock,
// in-order ID FIFO routing data_ok back to the issuing requester.
module sram_req_arbiter #(
    parameter int OT_DEPTH = 4,
    parameter int CNT_W    = $clog2(OT_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    sram_req_arbiter_if.slave bus,
    output logic [CNT_W-1:0] ot_cnt,
    output logic             proto_err
);
    localparam int PW = $clog2(OT_DEPTH);

    logic                r_lock_vld;
    logic                r_lock_id;
    logic [OT_DEPTH-1:0] r_fifo;
    logic [PW-1:0]       r_rd;
    logic [PW-1:0]       r_wr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic w_lock_hold;
    logic w_grant;
    logic w_req;
    logic w_full;
    logic w_mem_req;
    logic w_push;
    logic w_pop;
    logic w_head;

    // A dropped request releases the lock and lets D/I re-arbitrate this cycle.
    assign w_lock_hold = r_lock_vld &&
                         (r_lock_id ? bus.data_req : bus.inst_req);
    assign w_grant   = w_lock_hold ? r_lock_id : bus.data_req;
    assign w_req     = w_grant ? bus.data_req : bus.inst_req;
    assign w_full    = (r_cnt == CNT_W'(OT_DEPTH));
    assign w_mem_req = resetn && w_req && !w_full;
    assign w_push    = w_mem_req && bus.mem_addr_ok;
    assign w_pop     = resetn && bus.mem_data_ok && (r_cnt != '0);
    assign w_head    = r_fifo[r_rd];

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_wr    = w_grant ? bus.data_wr    : bus.inst_wr;
    assign bus.mem_size  = w_grant ? bus.data_size  : bus.inst_size;
    assign bus.mem_wstrb = w_grant ? bus.data_wstrb : bus.inst_wstrb;
    assign bus.mem_addr  = w_grant ? bus.data_addr  : bus.inst_addr;
    assign bus.mem_wdata = w_grant ? bus.data_wdata : bus.inst_wdata;

    assign bus.inst_addr_ok = w_push && !w_grant;
    assign bus.data_addr_ok = w_push && w_grant;
    assign bus.inst_data_ok = w_pop && !w_head;
    assign bus.data_data_ok = w_pop && w_head;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    assign ot_cnt    = r_cnt;
    assign proto_err = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
        end else begin
            r_lock_vld <= w_mem_req && !bus.mem_addr_ok;
            r_lock_id  <= w_grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fifo <= '0;
            r_wr   <= '0;
        end else if (w_push) begin
            r_fifo[r_wr] <= w_grant;
            r_wr         <= r_wr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd <= '0;
        end else if (w_pop) begin
            r_rd <= r_rd + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Response with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (bus.mem_data_ok && (r_cnt == '0)) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed-vector bench for sram_req_arbiter.
// Inputs change 1ns after posedge; outputs sampled at the following negedge.
module tb_sram_req_arbiter;
    logic       clk;
    logic       resetn;
    logic [2:0] ot_cnt;
    logic       proto_err;
    int         total;
    int         bad;

    sram_req_arbiter_if bus();

    sram_req_arbiter #(.OT_DEPTH(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .ot_cnt   (ot_cnt),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 2'd2;
        bus.inst_wstrb = 4'hf; bus.inst_addr = '0; bus.inst_wdata = '0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2;
        bus.data_wstrb = 4'hf; bus.data_addr = '0; bus.data_wdata = '0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset;
        idle();
        resetn = 0;
        bus.inst_req = 1;
        bus.mem_addr_ok = 1;
        #4;
        total++;
        if (ot_cnt !== 3'd0) begin
            bad++; $display("FAIL rst_cnt got=%0d exp=0", ot_cnt);
        end
        total++;
        if (bus.mem_req !== 1'b0 || bus.inst_addr_ok !== 1'b0) begin
            bad++; $display("FAIL rst_req got=%b%b exp=00", bus.mem_req, bus.inst_addr_ok);
        end
        total++;
        if (proto_err !== 1'b0) begin
            bad++; $display("FAIL rst_err got=%b exp=0", proto_err);
        end
        tick();
        idle();
        resetn = 1;
        tick();
    endtask

    task automatic test_single_fetch;
        bus.inst_req = 1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1;
        #4;
        total++;
        if (bus.mem_req !== 1 || bus.mem_addr !== 32'h1c000000) begin
            bad++; $display("FAIL sf_fwd got=%b %h exp=1 1c000000", bus.mem_req, bus.mem_addr);
        end
        total++;
        if (bus.inst_addr_ok !== 1 || bus.data_addr_ok !== 0) begin
            bad++; $display("FAIL sf_aok got=%b%b exp=10", bus.inst_addr_ok, bus.data_addr_ok);
        end
        tick(); idle(); #4;
        total++;
        if (ot_cnt !== 3'd1) begin
            bad++; $display("FAIL sf_cnt1 got=%0d exp=1", ot_cnt);
        end
        tick();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h12345678;
        #4;
        total++;
        if (ot_cnt !== 3'd1 || bus.inst_data_ok !== 1 || bus.data_data_ok !== 0) begin
            bad++; $display("FAIL sf_dok got=%0d %b%b exp=1 10", ot_cnt, bus.inst_data_ok, bus.data_data_ok);
        end
        total++;
        if (bus.inst_rdata !== 32'h12345678) begin
            bad++; $display("FAIL sf_rdata got=%h exp=12345678", bus.inst_rdata);
        end
        tick(); idle(); #4;
        total++;
        if (ot_cnt !== 3'd0) begin
            bad++; $display("FAIL sf_cnt0 got=%0d exp=0", ot_cnt);
        end
        tick();
    endtask

    task automatic test_contention;
        bus.inst_req = 1; bus.inst_addr = 32'h1c000004;
        bus.data_req = 1; bus.data_addr = 32'h00001000;
        bus.mem_addr_ok = 1;
        #4;
        total++;
        if (bus.mem_addr !== 32'h00001000 || bus.data_addr_ok !== 1 || bus.inst_addr_ok !== 0) begin
            bad++; $display("FAIL ct_d got=%h %b%b exp=00001000 10", bus.mem_addr, bus.data_addr_ok, bus.inst_addr_ok);
        end
        tick();
        bus.data_req = 0;
        #4;
        total++;
        if (bus.mem_addr !== 32'h1c000004 || bus.inst_addr_ok !== 1) begin
            bad++; $display("FAIL ct_i got=%h %b exp=1c000004 1", bus.mem_addr, bus.inst_addr_ok);
        end
        tick(); idle();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'haaaa0001;
        #4;
        total++;
        if (bus.data_data_ok !== 1 || bus.inst_data_ok !== 0 || bus.data_rdata !== 32'haaaa0001) begin
            bad++; $display("FAIL ct_r1 got=%b%b %h exp=10 aaaa0001", bus.data_data_ok, bus.inst_data_ok, bus.data_rdata);
        end
        tick();
        bus.mem_rdata = 32'hbbbb0002;
        #4;
        total++;
        if (bus.inst_data_ok !== 1 || bus.data_data_ok !== 0 || bus.inst_rdata !== 32'hbbbb0002) begin
            bad++; $display("FAIL ct_r2 got=%b%b %h exp=10 bbbb0002", bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata);
        end
        tick(); idle();
    endtask

    task automatic test_lock;
        bus.inst_req = 1; bus.inst_addr = 32'h1c000008;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                bus.data_req = 1; bus.data_addr = 32'h00002000;
            end
            #4;
            total++;
            if (bus.mem_addr !== 32'h1c000008 || bus.inst_addr_ok !== 0 || bus.data_addr_ok !== 0) begin
                bad++; $display("FAIL lk_stall%0d got=%h %b%b exp=1c000008 00", c, bus.mem_addr, bus.inst_addr_ok, bus.data_addr_ok);
            end
            tick();
        end
        bus.mem_addr_ok = 1;
        #4;
        total++;
        if (bus.mem_addr !== 32'h1c000008 || bus.inst_addr_ok !== 1 || bus.data_addr_ok !== 0) begin
            bad++; $display("FAIL lk_acc got=%h %b%b exp=1c000008 10", bus.mem_addr, bus.inst_addr_ok, bus.data_addr_ok);
        end
        tick();
        bus.inst_req = 0;
        #4;
        total++;
        if (bus.mem_addr !== 32'h00002000 || bus.data_addr_ok !== 1) begin
            bad++; $display("FAIL lk_d got=%h %b exp=00002000 1", bus.mem_addr, bus.data_addr_ok);
        end
        tick(); idle();
        bus.mem_data_ok = 1;
        #4;
        total++;
        if (ot_cnt !== 3'd2 || bus.inst_data_ok !== 1 || bus.data_data_ok !== 0) begin
            bad++; $display("FAIL lk_r1 got=%0d %b%b exp=2 10", ot_cnt, bus.inst_data_ok, bus.data_data_ok);
        end
        tick();
        #4;
        total++;
        if (bus.data_data_ok !== 1 || bus.inst_data_ok !== 0) begin
            bad++; $display("FAIL lk_r2 got=%b%b exp=10", bus.data_data_ok, bus.inst_data_ok);
        end
        tick(); idle();
    endtask

    task automatic test_full;
        bus.inst_req = 1; bus.mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            bus.inst_addr = 32'h1c000100 + 32'(i * 4);
            #4;
            total++;
            if (bus.inst_addr_ok !== 1) begin
                bad++; $display("FAIL fu_acc%0d got=%b exp=1", i, bus.inst_addr_ok);
            end
            tick();
        end
        bus.inst_addr = 32'h1c000200;
        bus.data_req = 1; bus.data_addr = 32'h00003000;
        #4;
        total++;
        if (ot_cnt !== 3'd4 || bus.mem_req !== 0 || bus.inst_addr_ok !== 0 || bus.data_addr_ok !== 0) begin
            bad++; $display("FAIL fu_blk got=%0d %b%b%b exp=4 000", ot_cnt, bus.mem_req, bus.inst_addr_ok, bus.data_addr_ok);
        end
        tick();
        bus.data_req = 0;
        bus.mem_data_ok = 1;
        #4;
        total++;
        if (bus.mem_req !== 0 || bus.inst_data_ok !== 1) begin
            bad++; $display("FAIL fu_nobyp got=%b %b exp=0 1", bus.mem_req, bus.inst_data_ok);
        end
        tick();
        bus.mem_data_ok = 0;
        #4;
        total++;
        if (ot_cnt !== 3'd3 || bus.mem_req !== 1 || bus.inst_addr_ok !== 1 || bus.mem_addr !== 32'h1c000200) begin
            bad++; $display("FAIL fu_fwd got=%0d %b%b %h exp=3 11 1c000200", ot_cnt, bus.mem_req, bus.inst_addr_ok, bus.mem_addr);
        end
        tick(); idle();
        bus.mem_data_ok = 1;
        repeat (4) tick();
        idle(); #4;
        total++;
        if (ot_cnt !== 3'd0) begin
            bad++; $display("FAIL fu_drain got=%0d exp=0", ot_cnt);
        end
        tick();
    endtask

    task automatic test_push_pop_spurious;
        bus.data_req = 1; bus.mem_addr_ok = 1;
        tick();
        bus.data_req = 0; bus.inst_req = 1;
        tick();
        bus.mem_data_ok = 1;
        #4;
        total++;
        if (ot_cnt !== 3'd2 || bus.data_data_ok !== 1 || bus.inst_data_ok !== 0 || bus.inst_addr_ok !== 1) begin
            bad++; $display("FAIL pp_same got=%0d %b%b%b exp=2 101", ot_cnt, bus.data_data_ok, bus.inst_data_ok, bus.inst_addr_ok);
        end
        tick(); idle();
        bus.mem_data_ok = 1;
        #4;
        total++;
        if (ot_cnt !== 3'd2 || bus.inst_data_ok !== 1) begin
            bad++; $display("FAIL pp_hold got=%0d %b exp=2 1", ot_cnt, bus.inst_data_ok);
        end
        tick(); #4;
        total++;
        if (bus.inst_data_ok !== 1 || proto_err !== 0) begin
            bad++; $display("FAIL pp_last got=%b err=%b exp=1 0", bus.inst_data_ok, proto_err);
        end
        tick();
        #4;
        total++;
        if (ot_cnt !== 3'd0 || bus.inst_data_ok !== 0 || bus.data_data_ok !== 0) begin
            bad++; $display("FAIL sp_drop got=%0d %b%b exp=0 00", ot_cnt, bus.inst_data_ok, bus.data_data_ok);
        end
        tick(); idle(); #4;
        total++;
        if (proto_err !== 1) begin
            bad++; $display("FAIL sp_err got=%b exp=1", proto_err);
        end
        tick(); tick(); #4;
        total++;
        if (proto_err !== 1 || ot_cnt !== 3'd0) begin
            bad++; $display("FAIL sp_sticky got=%b %0d exp=1 0", proto_err, ot_cnt);
        end
        tick();
    endtask

    task automatic test_async_reset;
        bus.inst_req = 1; bus.mem_addr_ok = 1;
        tick(); tick();
        bus.mem_addr_ok = 0;
        tick();
        #2;
        resetn = 0;
        #1;
        total++;
        if (ot_cnt !== 3'd0 || bus.mem_req !== 0 || proto_err !== 0) begin
            bad++; $display("FAIL ar_now got=%0d %b %b exp=0 0 0", ot_cnt, bus.mem_req, proto_err);
        end
        tick();
        resetn = 1;
        bus.data_req = 1; bus.data_addr = 32'h00004000;
        #4;
        total++;
        if (bus.mem_addr !== 32'h00004000 || bus.mem_req !== 1) begin
            bad++; $display("FAIL ar_unlock got=%h %b exp=00004000 1", bus.mem_addr, bus.mem_req);
        end
        tick(); idle();
        bus.mem_data_ok = 1;
        #4;
        total++;
        if (bus.inst_data_ok !== 0 || bus.data_data_ok !== 0) begin
            bad++; $display("FAIL ar_late got=%b%b exp=00", bus.inst_data_ok, bus.data_data_ok);
        end
        tick(); idle(); #4;
        total++;
        if (proto_err !== 1) begin
            bad++; $display("FAIL ar_err got=%b exp=1", proto_err);
        end
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock();
        test_full();
        test_push_pop_spurious();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
